// File: rtl/rcc_div_seq_ctrl_if.sv
// Signal bundle between the RCC register decode (master) and the divider
// reconfiguration sequencer (slave).
interface rcc_div_seq_ctrl_if;
    logic        cfg_wr;
    logic [23:0] cfg_wdata;
    logic        APB_ACTIVE;
    logic        clk_en;
    logic [7:0]  div_pclk;
    logic [7:0]  div_timclk;
    logic [7:0]  div_wdog;
    logic        div_load;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        err_timeout;

    modport master (
        output cfg_wr, cfg_wdata, APB_ACTIVE,
        input  clk_en, div_pclk, div_timclk, div_wdog, div_load,
               busy, done, overrun, err_timeout
    );

    modport slave (
        input  cfg_wr, cfg_wdata, APB_ACTIVE,
        output clk_en, div_pclk, div_timclk, div_wdog, div_load,
               busy, done, overrun, err_timeout
    );
endinterface

// File: rtl/rcc_div_seq_ctrl.sv
// Glitch-free RCC divider reconfiguration: wait for APB idle, gate, load, settle, ungate.
// Optional APB-idle timeout is enabled by defining RCC_DIV_SEQ_TIMEOUT_EN.
module rcc_div_seq_ctrl #(
    parameter int unsigned GATE_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [7:0]  DEF_PDIV       = 8'd1,
    parameter logic [7:0]  DEF_TDIV       = 8'd1,
    parameter logic [7:0]  DEF_WDIV       = 8'd1
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    rcc_div_seq_ctrl_if.slave bus
);

    localparam int unsigned GS_MAX  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX = (GS_MAX > TIMEOUT_CYCLES) ? GS_MAX : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef RCC_DIV_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {IDLE, WAIT_IDLE, GATE, SETTLE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [23:0]      act, act_nxt;
    logic [23:0]      pend, pend_nxt;
    logic             pend_v, pend_v_nxt;
    logic             clk_en_q, clk_en_nxt;
    logic [7:0]       pdiv, pdiv_nxt;
    logic [7:0]       tdiv, tdiv_nxt;
    logic [7:0]       wdiv, wdiv_nxt;
    logic             load_q, load_nxt;
    logic             done_q, done_nxt;
    logic             ovr_q, ovr_nxt;
    logic             tmo_q, tmo_nxt;
    logic             req;

    // An all-zero write would change nothing, so it is not treated as a request.
    assign req = bus.cfg_wr && (bus.cfg_wdata != 24'd0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            cnt      <= '0;
            act      <= '0;
            pend     <= '0;
            pend_v   <= 1'b0;
            clk_en_q <= 1'b1;
            pdiv     <= DEF_PDIV;
            tdiv     <= DEF_TDIV;
            wdiv     <= DEF_WDIV;
            load_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            act      <= act_nxt;
            pend     <= pend_nxt;
            pend_v   <= pend_v_nxt;
            clk_en_q <= clk_en_nxt;
            pdiv     <= pdiv_nxt;
            tdiv     <= tdiv_nxt;
            wdiv     <= wdiv_nxt;
            load_q   <= load_nxt;
            done_q   <= done_nxt;
            ovr_q    <= ovr_nxt;
            tmo_q    <= tmo_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        act_nxt    = act;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        clk_en_nxt = clk_en_q;
        pdiv_nxt   = pdiv;
        tdiv_nxt   = tdiv;
        wdiv_nxt   = wdiv;
        load_nxt   = 1'b0;
        done_nxt   = 1'b0;
        ovr_nxt    = 1'b0;
        tmo_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (pend_v) begin
                    act_nxt    = pend;
                    pend_v_nxt = 1'b0;
                    cnt_nxt    = '0;
                    state_nxt  = WAIT_IDLE;
                end else if (req) begin
                    act_nxt   = bus.cfg_wdata;
                    cnt_nxt   = '0;
                    state_nxt = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (!bus.APB_ACTIVE) begin
                    clk_en_nxt = 1'b0;
                    cnt_nxt    = '0;
                    state_nxt  = GATE;
                end
`ifdef RCC_DIV_SEQ_TIMEOUT_EN
                else if (cnt == TMO_LAST) begin
                    tmo_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
`endif
            end
            GATE: begin
                if (cnt == GATE_LAST) begin
                    if (act[7:0]   != 8'd0) pdiv_nxt = act[7:0];
                    if (act[15:8]  != 8'd0) tdiv_nxt = act[15:8];
                    if (act[23:16] != 8'd0) wdiv_nxt = act[23:16];
                    load_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = SETTLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    clk_en_nxt = 1'b1;
                    done_nxt   = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Requests not taken straight into the active slot land in the one-deep buffer;
        // a buffer being drained into the active slot this cycle is not an overwrite.
        if (req && !(state == IDLE && !pend_v)) begin
            pend_nxt   = bus.cfg_wdata;
            pend_v_nxt = 1'b1;
            ovr_nxt    = pend_v && (state != IDLE);
        end
    end

    assign bus.clk_en      = clk_en_q;
    assign bus.div_pclk    = pdiv;
    assign bus.div_timclk  = tdiv;
    assign bus.div_wdog    = wdiv;
    assign bus.div_load    = load_q;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.overrun     = ovr_q;
    assign bus.err_timeout = tmo_q;

endmodule

// File: tb/tb_rcc_div_seq_ctrl.sv
// Bench for rcc_div_seq_ctrl: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rcc_div_seq_ctrl;

    localparam int GC = 2;
    localparam int SC = 4;
    localparam int TC = 256;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b1;

    rcc_div_seq_ctrl_if bus();

    rcc_div_seq_ctrl #(
        .GATE_CYCLES(GC), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC),
        .DEF_PDIV(8'd1), .DEF_TDIV(8'd1), .DEF_WDIV(8'd1)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .bus(bus)
    );

    always #5 HCLK = ~HCLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chkEn = 1'b0;

    int ovrSeen = 0, doneSeen = 0, loadSeen = 0, busySeen = 0, tmoSeen = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference model: a sequence is described by the edge at which gating began;
    // load and completion follow at fixed offsets from that edge.
    bit         m_run = 0, m_pendv = 0, m_clkEn = 1;
    bit         m_load = 0, m_done = 0, m_ovr = 0, m_tmo = 0;
    logic [23:0] m_act = '0, m_pend = '0;
    logic [7:0] m_div [3] = '{8'd1, 8'd1, 8'd1};
    int         m_gateAt = -1, m_wait = 0;
    bit         req, took, hadPend, consumed;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_run = 0; m_pendv = 0; m_clkEn = 1;
            m_load = 0; m_done = 0; m_ovr = 0; m_tmo = 0;
            m_div = '{8'd1, 8'd1, 8'd1};
            m_gateAt = -1; m_wait = 0;
        end else begin
            cyc++;
            req = bus.cfg_wr && (bus.cfg_wdata != 24'd0);
            hadPend = m_pendv; consumed = 0; took = 0;
            m_load = 0; m_done = 0; m_ovr = 0; m_tmo = 0;
            if (!m_run) begin
                if (m_pendv) begin
                    m_act = m_pend; m_pendv = 0; consumed = 1;
                    m_run = 1; m_gateAt = -1; m_wait = 0;
                end else if (req) begin
                    m_act = bus.cfg_wdata; took = 1;
                    m_run = 1; m_gateAt = -1; m_wait = 0;
                end
            end else if (m_gateAt < 0) begin
                if (!bus.APB_ACTIVE) begin
                    m_gateAt = cyc; m_clkEn = 0;
                end
`ifdef RCC_DIV_SEQ_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait == TC) begin m_tmo = 1; m_run = 0; end
                end
`endif
            end else if (cyc == m_gateAt + GC) begin
                for (int f = 0; f < 3; f++)
                    if (m_act[8*f +: 8] != 8'd0) m_div[f] = m_act[8*f +: 8];
                m_load = 1;
            end else if (cyc == m_gateAt + GC + SC) begin
                m_clkEn = 1; m_done = 1; m_run = 0;
            end
            if (req && !took) begin
                m_ovr = hadPend && !consumed;
                m_pend = bus.cfg_wdata; m_pendv = 1;
            end
        end
    end

    always @(negedge HCLK) begin
        if (chkEn) begin
            checkOutput("cmp_clk_en", bus.clk_en, m_clkEn);
            checkOutput("cmp_div_pclk", bus.div_pclk, m_div[0]);
            checkOutput("cmp_div_timclk", bus.div_timclk, m_div[1]);
            checkOutput("cmp_div_wdog", bus.div_wdog, m_div[2]);
            checkOutput("cmp_div_load", bus.div_load, m_load);
            checkOutput("cmp_busy", bus.busy, m_run);
            checkOutput("cmp_done", bus.done, m_done);
            checkOutput("cmp_overrun", bus.overrun, m_ovr);
            checkOutput("cmp_err_timeout", bus.err_timeout, m_tmo);
        end
        if (HRESETn) begin
            if (bus.overrun) ovrSeen++;
            if (bus.done) doneSeen++;
            if (bus.div_load) loadSeen++;
            if (bus.busy) busySeen++;
            if (bus.err_timeout) tmoSeen++;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [23:0] data, input logic apb);
        @(posedge HCLK);
        #1;
        bus.cfg_wr = wr;
        bus.cfg_wdata = data;
        bus.APB_ACTIVE = apb;
    endtask

    task automatic waitDone(input string name, input int budget);
        int start;
        int n;
        start = doneSeen;
        n = 0;
        while (doneSeen == start && n < budget) begin
            waitCycles(1);
            n++;
        end
        checkOutput(name, 32'(doneSeen != start), 1);
    endtask

    initial begin
        int dones, lows, tmoAt;
        bus.cfg_wr = 0; bus.cfg_wdata = '0; bus.APB_ACTIVE = 0;
        #2 HRESETn = 0;
        #1 chkEn = 1;
        #20;
        @(negedge HCLK) HRESETn = 1;

        // Idle after reset: everything holds, no pulses.
        ovrSeen = 0; doneSeen = 0; loadSeen = 0; busySeen = 0; tmoSeen = 0;
        waitCycles(20);
        checkOutput("t1_clk_en", bus.clk_en, 1);
        checkOutput("t1_divs", {bus.div_wdog, bus.div_timclk, bus.div_pclk}, 24'h010101);
        checkOutput("t1_no_activity", busySeen + doneSeen + loadSeen + ovrSeen, 0);

        // Basic sequence 0x040208 with APB idle; cfg_wr sampled at edge k.
        applyStimulus(1, 24'h040208, 0);
        applyStimulus(0, 24'h0, 0);
        checkOutput("t2_clk_en_k", bus.clk_en, 1);
        waitCycles(1);
        checkOutput("t2_clk_en_k1", bus.clk_en, 0);
        checkOutput("t2_busy_k1", bus.busy, 1);
        waitCycles(1);
        checkOutput("t2_load_k2", bus.div_load, 0);
        waitCycles(1);
        checkOutput("t2_div_pclk_k3", bus.div_pclk, 8);
        checkOutput("t2_div_timclk_k3", bus.div_timclk, 2);
        checkOutput("t2_div_wdog_k3", bus.div_wdog, 4);
        checkOutput("t2_load_k3", bus.div_load, 1);
        waitCycles(3);
        checkOutput("t2_busy_k6", bus.busy, 1);
        checkOutput("t2_done_k6", bus.done, 0);
        waitCycles(1);
        checkOutput("t2_clk_en_k7", bus.clk_en, 1);
        checkOutput("t2_done_k7", bus.done, 1);
        checkOutput("t2_busy_k7", bus.busy, 0);
        waitCycles(1);
        checkOutput("t2_done_k8", bus.done, 0);

        // APB busy for 10 cycles delays gating.
        applyStimulus(1, 24'h060802, 1);
        applyStimulus(0, 24'h0, 1);
        for (int i = 0; i < 10; i++) begin
            waitCycles(1);
            checkOutput("t3_clk_en_hold", bus.clk_en, 1);
        end
        bus.APB_ACTIVE = 0;
        waitCycles(1);
        checkOutput("t3_clk_en_gate", bus.clk_en, 0);
        waitDone("t3_done_wait", 20);
        checkOutput("t3_divs", {bus.div_wdog, bus.div_timclk, bus.div_pclk}, 24'h060802);

        // Back-to-back with buffered requests and overruns.
        ovrSeen = 0;
        applyStimulus(1, 24'h0a0a0a, 0);
        applyStimulus(1, 24'h010101, 0);
        applyStimulus(1, 24'h020202, 0);
        applyStimulus(1, 24'h030303, 0);
        applyStimulus(0, 24'h0, 0);
        dones = 0; lows = 0;
        for (int i = 0; i < 60 && dones < 2; i++) begin
            waitCycles(1);
            if (bus.done) dones++;
            if (dones == 1 && !bus.busy) lows++;
        end
        checkOutput("t4_two_dones", dones, 2);
        checkOutput("t4_overruns", ovrSeen, 2);
        checkOutput("t4_busy_gap", lows, 1);
        checkOutput("t4_divs", {bus.div_wdog, bus.div_timclk, bus.div_pclk}, 24'h030303);

        // Zero fields keep current ratios; equal ratios still reload.
        applyStimulus(1, 24'h040208, 0);
        applyStimulus(0, 24'h0, 0);
        waitDone("t5_done_a", 20);
        applyStimulus(1, 24'h000010, 0);
        applyStimulus(0, 24'h0, 0);
        waitDone("t5_done_b", 20);
        checkOutput("t5_divs_keep", {bus.div_wdog, bus.div_timclk, bus.div_pclk}, 24'h040210);
        loadSeen = 0;
        applyStimulus(1, 24'h040210, 0);
        applyStimulus(0, 24'h0, 0);
        waitDone("t5_done_c", 20);
        checkOutput("t5_reload_pulse", loadSeen, 1);
        busySeen = 0; doneSeen = 0;
        applyStimulus(1, 24'h0, 0);
        applyStimulus(0, 24'h0, 0);
        waitCycles(10);
        checkOutput("t5_zero_no_busy", busySeen, 0);
        checkOutput("t5_zero_no_done", doneSeen, 0);

        // APB held busy for 300 cycles.
        tmoSeen = 0; tmoAt = -1;
        applyStimulus(1, 24'h111111, 1);
        applyStimulus(0, 24'h0, 1);
        for (int i = 1; i <= 300; i++) begin
            waitCycles(1);
            if (bus.err_timeout && tmoAt < 0) tmoAt = i;
        end
`ifdef RCC_DIV_SEQ_TIMEOUT_EN
        checkOutput("t6_tmo_cycle", tmoAt, 256);
        checkOutput("t6_tmo_count", tmoSeen, 1);
        checkOutput("t6_busy", bus.busy, 0);
        checkOutput("t6_clk_en", bus.clk_en, 1);
        checkOutput("t6_divs", {bus.div_wdog, bus.div_timclk, bus.div_pclk}, 24'h040210);
        bus.APB_ACTIVE = 0;
        waitCycles(2);
`else
        checkOutput("t6_no_tmo", tmoSeen, 0);
        checkOutput("t6_busy_300", bus.busy, 1);
        checkOutput("t6_clk_en_300", bus.clk_en, 1);
        bus.APB_ACTIVE = 0;
        waitDone("t6_done_wait", 20);
        checkOutput("t6_divs", {bus.div_wdog, bus.div_timclk, bus.div_pclk}, 24'h111111);
`endif

        // Asynchronous reset mid-GATE with a pending request.
        applyStimulus(1, 24'h050505, 0);
        applyStimulus(1, 24'h070707, 0);
        applyStimulus(0, 24'h0, 0);
        checkOutput("t7_gated", bus.clk_en, 0);
        #2 HRESETn = 0;
        #1;
        checkOutput("t7_rst_clk_en", bus.clk_en, 1);
        checkOutput("t7_rst_divs", {bus.div_wdog, bus.div_timclk, bus.div_pclk}, 24'h010101);
        checkOutput("t7_rst_busy", bus.busy, 0);
        @(negedge HCLK) HRESETn = 1;
        busySeen = 0;
        waitCycles(10);
        checkOutput("t7_pending_dropped", busySeen, 0);
        checkOutput("t7_divs_after", {bus.div_wdog, bus.div_timclk, bus.div_pclk}, 24'h010101);

        chkEn = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
